eagle_guard_ctrl: RTL

// Per-frame damage controller for the eagle (base) sprite. Once per refresh_tick, tests the enemy and tank bullets
// for overlap with the eagle box and drives the eagle life cycle: alive, hit-flash, destroyed, game over. Sits

---
 rtl/eagle_guard_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/eagle_guard_ctrl.sv
// Eagle (base) damage controller: per-frame bullet/eagle overlap test and the
// alive -> hit-flash -> destroyed -> game-over life cycle, with restart.
module eagle_guard_ctrl #(
  parameter int EAGLE_SIZE   = 32,
  parameter int BULLET_SIZE  = 4,
  parameter int HIT_POINTS   = 3,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_FRAMES = 4,
  parameter int OVER_FRAMES  = 120
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       restart,
  input  logic [9:0] x_eagle,
  input  logic [9:0] y_eagle,
  input  logic [9:0] x_enemy_bullet,
  input  logic [9:0] y_enemy_bullet,
  input  logic       enemy_bullet_valid,
  input  logic [9:0] x_tank_bullet,
  input  logic [9:0] y_tank_bullet,
  input  logic       tank_bullet_valid,
  output logic       enemy_bullet_hit,
  output logic       tank_bullet_hit,
  output logic [1:0] hits_left,
  output logic       eagle_visible,
  output logic       eagle_destroyed,
  output logic       game_over
);

  localparam int CNT_MAX = (OVER_FRAMES > FLASH_FRAMES) ? OVER_FRAMES : FLASH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [1:0]       HP_FULL    = 2'(HIT_POINTS);

  typedef enum logic [1:0] {ALIVE, FLASH, DESTROYED, OVER} state_t;

  state_t           state_q;
  logic [1:0]       hits_q;
  logic             vis_q;
  logic             dest_q;
  logic             over_q;
  logic             enemy_hit_q;
  logic             tank_hit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BLK_W-1:0] blink_q;

  logic enemy_ovl;
  logic tank_ovl;

  // Coordinates widened to 11 bits so box edges near 1023 never wrap.
  function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [9:0] xe, input logic [9:0] ye);
    logic [10:0] bx_w, by_w, xe_w, ye_w;
    bx_w = {1'b0, bx};
    by_w = {1'b0, by};
    xe_w = {1'b0, xe};
    ye_w = {1'b0, ye};
    return (bx_w < xe_w + 11'(EAGLE_SIZE)) && (bx_w + 11'(BULLET_SIZE) > xe_w) &&
           (by_w < ye_w + 11'(EAGLE_SIZE)) && (by_w + 11'(BULLET_SIZE) > ye_w);
  endfunction

  assign enemy_ovl = enemy_bullet_valid &&
                     overlap(x_enemy_bullet, y_enemy_bullet, x_eagle, y_eagle);
  assign tank_ovl  = tank_bullet_valid &&
                     overlap(x_tank_bullet, y_tank_bullet, x_eagle, y_eagle);

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= ALIVE;
      hits_q      <= HP_FULL;
      vis_q       <= 1'b1;
      dest_q      <= 1'b0;
      over_q      <= 1'b0;
      enemy_hit_q <= 1'b0;
      tank_hit_q  <= 1'b0;
      cnt_q       <= '0;
      blink_q     <= '0;
    end else if (restart) begin
      state_q     <= ALIVE;
      hits_q      <= HP_FULL;
      vis_q       <= 1'b1;
      dest_q      <= 1'b0;
      over_q      <= 1'b0;
      enemy_hit_q <= 1'b0;
      tank_hit_q  <= 1'b0;
      cnt_q       <= '0;
      blink_q     <= '0;
    end else begin
      enemy_hit_q <= 1'b0;
      tank_hit_q  <= 1'b0;
      if (refresh_tick) begin
        // The eagle and its wreck both stop bullets; only game-over lets them pass.
        if (state_q != OVER) begin
          enemy_hit_q <= enemy_ovl;
          tank_hit_q  <= tank_ovl;
        end
        case (state_q)
          ALIVE: begin
            if ((enemy_ovl || tank_ovl) && hits_q != 2'd0) begin
              hits_q  <= hits_q - 2'd1;
              cnt_q   <= '0;
              blink_q <= '0;
              if (hits_q == 2'd1) begin
                state_q <= DESTROYED;
                dest_q  <= 1'b1;
                vis_q   <= 1'b1;
              end else begin
                state_q <= FLASH;
                vis_q   <= 1'b0;
              end
            end
          end
          FLASH: begin
            if (cnt_q == FLASH_LAST) begin
              state_q <= ALIVE;
              vis_q   <= 1'b1;
              cnt_q   <= '0;
              blink_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
                vis_q   <= ~vis_q;
              end else begin
                blink_q <= blink_q + BLK_W'(1);
              end
            end
          end
          DESTROYED: begin
            if (cnt_q == OVER_LAST) begin
              state_q <= OVER;
              over_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          OVER: begin
            state_q <= OVER;
          end
          default: begin
            state_q <= ALIVE;
          end
        endcase
      end
    end
  end

  assign enemy_bullet_hit = enemy_hit_q;
  assign tank_bullet_hit  = tank_hit_q;
  assign hits_left        = hits_q;
  assign eagle_visible    = vis_q;
  assign eagle_destroyed  = dest_q;
  assign game_over        = over_q;

endmodule
